// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: the 4-bit op code values, the
// controller state encoding, and a helper that identifies the multi-cycle ops.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    // Op codes as seen on the alu_sel bus
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROTL = 4'd6,
        OP_ROTR = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Multiply and divide are the only ops that may take the iterative path
    function automatic logic is_muldiv(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// ----------------------------------------------------------------------------
// alu_pipe_if
// Handshake bundle between an ALU requester and the alu_pipe block.
//   in_valid/in_ready   : operation handshake (a, b, alu_sel qualified by it)
//   out_valid/out_ready : result handshake (alu_out, carry_out, zero)
// Modports: master = requester side, slave = alu_pipe side.
// ----------------------------------------------------------------------------
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry_out;
    logic             zero;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_out, carry_out, zero
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, alu_out, carry_out, zero
    );

endinterface

// File: rtl/alu_muldiv.sv
// ----------------------------------------------------------------------------
// alu_muldiv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// clock, WIDTH iterations per operation. Only instantiated by alu_pipe when
// the ALU_MUL_DIV_EN macro is defined.
// Ports:
//   clk, rst : clock and synchronous active-high reset (aborts any operation)
//   start    : load operands and begin; sampled on the rising edge
//   op       : OP_DIV selects divide, anything else multiplies
//   a, b     : operands (a * b, or a / b)
//   done     : high during the cycle whose rising edge performs the final
//              iteration; result/ovf are valid in that same cycle
//   result   : low product bits, or quotient (all ones on divide by zero)
//   ovf      : product high half nonzero, or divide by zero
// ----------------------------------------------------------------------------
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;

    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;

    // One iteration of either algorithm. For multiply acc_hi:acc_lo is the
    // partial product with the multiplier shifting out of acc_lo; for divide
    // acc_hi is the remainder and acc_lo shifts the dividend out while the
    // quotient bits shift in. The remainder is always below the divisor, so
    // the W-bit difference is exact.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        nxt_hi    = '0;
        nxt_lo    = '0;
        if (is_div) begin
            if (div_shift >= {1'b0, operand}) begin
                nxt_hi = div_shift[WIDTH-1:0] - operand;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Results are taken from the post-iteration values so the controller can
    // register them on the same edge as the last iteration. A zero divisor
    // makes every trial subtraction succeed, giving an all-ones quotient.
    assign done   = busy && (cnt == LAST);
    assign result = nxt_lo;
    assign ovf    = is_div ? (operand == '0) : (nxt_hi != '0);

    // Operand load, iteration counter and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            is_div  <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            is_div  <= (op == OP_DIV);
            acc_hi  <= '0;
            acc_lo  <= (op == OP_DIV) ? a : b;
            operand <= (op == OP_DIV) ? b : a;
        end else if (busy) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
// Handshaked ALU with a three-state controller (IDLE, CALC, DONE). Single
// cycle ops return their registered result one cycle after acceptance.
// Multiply/divide use the iterative alu_muldiv unit when the macro
// ALU_MUL_DIV_EN is defined (result WIDTH+1 cycles after acceptance);
// without it they complete in one cycle with alu_out=0 and carry_out=1.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; aborts any operation in flight
//   bus  : alu_pipe_if slave modport (operation in, result out)
// ----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    alu_pipe_if.slave  bus
);

    alu_state_e       state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_out_q;
    logic             carry_q;
    logic             zero_q;

    alu_op_e          sel;
    logic             accept;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH-1:0] comb_res;
    logic             comb_carry;

    assign sel    = alu_op_e'(bus.alu_sel);
    assign accept = bus.in_valid && in_ready_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;

    // Single-cycle result and flag, computed straight from the bus so that
    // registering them on the accepting edge captures the operands.
    // Multiply/divide fall through to the "not available" answer, which is
    // only used when the iterative unit is not built.
    always_comb begin
        add_ext    = {1'b0, bus.a} + {1'b0, bus.b};
        comb_res   = '0;
        comb_carry = 1'b0;
        case (sel)
            OP_ADD: begin
                comb_res   = add_ext[WIDTH-1:0];
                comb_carry = add_ext[WIDTH];
            end
            OP_SUB: begin
                comb_res   = bus.a - bus.b;
                comb_carry = (bus.a < bus.b);
            end
            OP_MUL, OP_DIV: begin
                comb_res   = '0;
                comb_carry = 1'b1;
            end
            OP_SHL: begin
                comb_res   = {bus.a[WIDTH-2:0], 1'b0};
                comb_carry = bus.a[WIDTH-1];
            end
            OP_SHR: begin
                comb_res   = {1'b0, bus.a[WIDTH-1:1]};
                comb_carry = bus.a[0];
            end
            OP_ROTL: comb_res = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
            OP_ROTR: comb_res = {bus.a[0], bus.a[WIDTH-1:1]};
            OP_AND:  comb_res = bus.a & bus.b;
            OP_OR:   comb_res = bus.a | bus.b;
            OP_XOR:  comb_res = bus.a ^ bus.b;
            OP_NOR:  comb_res = ~(bus.a | bus.b);
            OP_NAND: comb_res = ~(bus.a & bus.b);
            OP_XNOR: comb_res = ~(bus.a ^ bus.b);
            OP_GT:   comb_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            OP_EQ:   comb_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            default: begin
                comb_res   = '0;
                comb_carry = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_DIV_EN
    logic             md_start;
    logic             md_done;
    logic             md_ovf;
    logic [WIDTH-1:0] md_result;

    assign md_start = accept && is_muldiv(sel);

    alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (sel),
        .a      (bus.a),
        .b      (bus.b),
        .done   (md_done),
        .result (md_result),
        .ovf    (md_ovf)
    );
`endif

    // Controller: accepts in IDLE, waits for the iterative unit in CALC and
    // holds the registered result in DONE until the consumer takes it.
    // in_ready and out_valid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
`ifdef ALU_MUL_DIV_EN
                        if (is_muldiv(sel)) begin
                            state <= CALC;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            alu_out_q   <= comb_res;
                            carry_q     <= comb_carry;
                            zero_q      <= (comb_res == '0);
                        end
`else
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= comb_res;
                        carry_q     <= comb_carry;
                        zero_q      <= (comb_res == '0);
`endif
                    end
                end
                CALC: begin
`ifdef ALU_MUL_DIV_EN
                    if (md_done) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= md_result;
                        carry_q     <= md_ovf;
                        zero_q      <= (md_result == '0);
                    end
`else
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_pipe
// Directed self-checking bench for alu_pipe at WIDTH=8. Expected values are
// hand-computed constants; multiply/divide expectations follow whether
// ALU_MUL_DIV_EN is defined for the build.
// ----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int WIDTH = 8;
`ifdef ALU_MUL_DIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int MD_LAT = MD_EN ? WIDTH + 1 : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int check_count = 0;
    int pass_count  = 0;

    logic [7:0] sweep_out   [16];
    logic       sweep_carry [16];
    logic       sweep_zero  [16];
    int         sweep_lat   [16];

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single comparison point
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Present one operation and hold in_valid until it is accepted; the
    // operands are scrambled right after acceptance.
    task automatic apply_stimulus(input string tag, input logic [7:0] a_in,
                                  input logic [7:0] b_in, input logic [3:0] sel);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_output({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.a        = a_in;
        bus.b        = b_in;
        bus.alu_sel  = sel;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a_in;
        bus.b        = ~b_in;
        bus.alu_sel  = ~sel;
    endtask

    // Wait for out_valid, counting cycles since acceptance, then check outputs
    task automatic wait_result(input string tag, input int exp_lat, input logic [7:0] exp_out,
                               input logic exp_carry, input logic exp_zero);
        int lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({tag, "_latency"}, lat, exp_lat);
        check_output({tag, "_alu_out"}, {24'd0, bus.alu_out}, {24'd0, exp_out});
        check_output({tag, "_carry"}, {31'd0, bus.carry_out}, {31'd0, exp_carry});
        check_output({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
        check_output({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
    endtask

    // Take the result and confirm the block is ready again
    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_output({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
        check_output({tag, "_ready_again"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a_in, input logic [7:0] b_in,
                          input logic [3:0] sel, input int exp_lat, input logic [7:0] exp_out,
                          input logic exp_carry, input logic exp_zero);
        apply_stimulus(tag, a_in, b_in, sel);
        wait_result(tag, exp_lat, exp_out, exp_carry, exp_zero);
        consume(tag);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_sel   = '0;
        bus.out_ready = 1'b0;

        sweep_out   = '{8'h0C, 8'h08, MD_EN ? 8'h14 : 8'h00, MD_EN ? 8'h05 : 8'h00,
                        8'h14, 8'h05, 8'h14, 8'h05, 8'h02, 8'h0A, 8'h08, 8'hF5,
                        8'hFD, 8'hF7, 8'h01, 8'h00};
        sweep_carry = '{1'b0, 1'b0, !MD_EN, !MD_EN, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        sweep_zero  = '{1'b0, 1'b0, !MD_EN, !MD_EN, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        sweep_lat   = '{1, 1, MD_LAT, MD_LAT, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

        $display("[TB] start, ALU_MUL_DIV_EN=%0d", MD_EN);

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_output("reset_alu_out", {24'd0, bus.alu_out}, 32'd0);
        check_output("reset_carry", {31'd0, bus.carry_out}, 32'd0);
        check_output("reset_zero", {31'd0, bus.zero}, 32'd0);

        // Scenario 1 and 2: add, add wrapping to zero, sub with borrow
        run_op("s1_add", 8'h0A, 8'h02, 4'd0, 1, 8'h0C, 1'b0, 1'b0);
        run_op("s2_add_wrap", 8'hF6, 8'h0A, 4'd0, 1, 8'h00, 1'b1, 1'b1);
        run_op("s2_sub_borrow", 8'h02, 8'h05, 4'd1, 1, 8'hFD, 1'b1, 1'b0);

        // Scenario 3: multiply overflowing the low half, then divide
        run_op("s3_mul", 8'h10, 8'h10, 4'd2, MD_LAT, 8'h00, 1'b1, 1'b1);
        run_op("s3_div", 8'h64, 8'h07, 4'd3, MD_LAT, MD_EN ? 8'h0E : 8'h00,
               !MD_EN, !MD_EN);

        // Scenario 4: divide by zero, result held while out_ready stays low
        apply_stimulus("s4_div0", 8'h55, 8'h00, 4'd3);
        wait_result("s4_div0", MD_LAT, MD_EN ? 8'hFF : 8'h00, 1'b1, !MD_EN);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output("s4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check_output("s4_hold_out", {24'd0, bus.alu_out}, MD_EN ? 32'hFF : 32'h00);
            check_output("s4_hold_carry", {31'd0, bus.carry_out}, 32'd1);
            check_output("s4_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        consume("s4_div0");

        // Scenario 5: reset pulse in cycle 4 of a multiply aborts it
        apply_stimulus("s5_mul", 8'h10, 8'h10, 4'd2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("s5_abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("s5_abort_ready", {31'd0, bus.in_ready}, 32'd1);
        check_output("s5_abort_out", {24'd0, bus.alu_out}, 32'd0);
        check_output("s5_abort_carry", {31'd0, bus.carry_out}, 32'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check_output("s5_no_stale_valid", {31'd0, bus.out_valid}, 32'd0);
        run_op("s5_add_after", 8'h0A, 8'h02, 4'd0, 1, 8'h0C, 1'b0, 1'b0);

        // Scenario 6: sweep every op code with a=0x0A, b=0x02
        for (int s = 0; s < 16; s++) begin
            run_op($sformatf("s6_sel%0d", s), 8'h0A, 8'h02, 4'(s),
                   sweep_lat[s], sweep_out[s], sweep_carry[s], sweep_zero[s]);
        end

        // Boundary cases: shifted-out bits set, equal operands
        run_op("edge_shl_msb", 8'h81, 8'h00, 4'd4, 1, 8'h02, 1'b1, 1'b0);
        run_op("edge_shr_lsb", 8'h81, 8'h00, 4'd5, 1, 8'h40, 1'b1, 1'b0);
        run_op("edge_rotr", 8'h81, 8'h00, 4'd7, 1, 8'hC0, 1'b0, 1'b0);
        run_op("edge_sub_equal", 8'h05, 8'h05, 4'd1, 1, 8'h00, 1'b0, 1'b1);
        run_op("edge_gt_equal", 8'h05, 8'h05, 4'd14, 1, 8'h00, 1'b0, 1'b1);
        run_op("edge_eq_equal", 8'h05, 8'h05, 4'd15, 1, 8'h01, 1'b0, 1'b0);
        run_op("edge_mul_max", 8'hFF, 8'hFF, 4'd2, MD_LAT, MD_EN ? 8'h01 : 8'h00,
               1'b1, !MD_EN);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
